// File: rtl/freelist_recovery_ctrl_pkg.sv
// Shared system definitions for the free-list recovery walker.
// Sizing comes from the FLRC_* macros, which can be overridden on the command line.
`ifndef FLRC_N_WAY
`define FLRC_N_WAY 2
`endif
`ifndef FLRC_N_ROB
`define FLRC_N_ROB 8
`endif
`ifndef FLRC_CDB_BITS
`define FLRC_CDB_BITS 6
`endif
`ifndef FLRC_ZERO_REG_PR
`define FLRC_ZERO_REG_PR 0
`endif

package freelist_recovery_ctrl_pkg;

  localparam int N_WAY       = `FLRC_N_WAY;
  localparam int N_ROB       = `FLRC_N_ROB;
  localparam int CDB_BITS    = `FLRC_CDB_BITS;
  localparam int ZERO_REG_PR = `FLRC_ZERO_REG_PR;

  localparam int IDX_W = $clog2(N_ROB);
  localparam int REM_W = IDX_W + 1;

  typedef logic [IDX_W-1:0]    rob_idx_t;
  typedef logic [REM_W-1:0]    rem_t;
  typedef logic [CDB_BITS-1:0] phys_tag_t;

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC_WALK = 2'd1,
    REC_DONE = 2'd2
  } rec_state_t;

  // (a - b) mod N_ROB, valid for any ROB depth, not only powers of two
  function automatic rob_idx_t rob_wrap_sub(input rob_idx_t a, input rem_t b);
    int t;
    t = (int'(a) + N_ROB - (int'(b) % N_ROB)) % N_ROB;
    return rob_idx_t'(t);
  endfunction

endpackage

// File: rtl/freelist_recovery_ctrl_ptr.sv
// rob_walk_ptr: walk pointer, stop index and the entries still to be released.
// next_remaining is the span after this cycle's load/step/stop update.
module rob_walk_ptr
  import freelist_recovery_ctrl_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     load,
  input  logic     set_stop,
  input  logic     step_en,
  input  rob_idx_t load_ptr,
  input  rob_idx_t load_stop,
  output rob_idx_t ptr,
  output rem_t     remaining,
  output rem_t     next_remaining
);

  rob_idx_t stop;
  rob_idx_t ptr_next;
  rob_idx_t stop_next;
  rem_t     step;

  function automatic rem_t span(input rob_idx_t p, input rob_idx_t s);
    return rem_t'(rob_wrap_sub(rob_wrap_sub(p, rem_t'(s)), rem_t'(1)));
  endfunction

  assign remaining = span(ptr, stop);
  assign step      = (remaining > rem_t'(N_WAY)) ? rem_t'(N_WAY) : remaining;

  // A squash while walking only moves the stop; the pointer keeps stepping
  always_comb begin
    ptr_next  = ptr;
    stop_next = stop;
    if (load) begin
      ptr_next  = load_ptr;
      stop_next = load_stop;
    end else begin
      if (step_en) ptr_next = rob_wrap_sub(ptr, step);
      if (set_stop) stop_next = load_stop;
    end
  end

  assign next_remaining = span(ptr_next, stop_next);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr  <= '0;
      stop <= '0;
    end else begin
      ptr  <= ptr_next;
      stop <= stop_next;
    end
  end

endmodule

// File: rtl/freelist_recovery_ctrl.sv
// Free-list recovery controller: walks squashed ROB entries youngest-first and returns their T tags.
// Optional FLRC_PERF_EN adds saturating walk-entry and walk-cycle counters.
module freelist_recovery_ctrl
  import freelist_recovery_ctrl_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            squash_valid,
  input  logic [IDX_W-1:0]                squash_idx,
  input  logic [IDX_W-1:0]                tail_idx,
  output logic [N_WAY-1:0][IDX_W-1:0]     rob_rd_idx,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]  rob_rd_t,
  output logic [N_WAY-1:0]                free_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0]  free_tag,
  input  logic                            free_ready,
  output logic                            dispatch_stall,
  output logic                            busy,
  output logic                            rec_done,
  output logic [15:0]                     rec_count,
  output logic [15:0]                     rec_cycles
);

  rec_state_t state;
  rec_state_t state_next;
  rob_idx_t   ptr;
  rem_t       remaining;
  rem_t       next_remaining;
  logic       load;
  logic       set_stop;
  logic       step_en;

  assign load     = squash_valid && ((state == REC_IDLE) || (state == REC_DONE));
  assign set_stop = squash_valid && (state == REC_WALK);
  assign step_en  = free_ready && (state == REC_WALK);

  rob_walk_ptr u_walk_ptr (
    .clock          (clock),
    .reset          (reset),
    .load           (load),
    .set_stop       (set_stop),
    .step_en        (step_en),
    .load_ptr       (tail_idx),
    .load_stop      (squash_idx),
    .ptr            (ptr),
    .remaining      (remaining),
    .next_remaining (next_remaining)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= REC_IDLE;
    else        state <= state_next;
  end

  // A squash arriving in DONE restarts the walk and swallows the completion pulse
  always_comb begin
    state_next     = state;
    busy           = 1'b0;
    dispatch_stall = 1'b0;
    rec_done       = 1'b0;
    case (state)
      REC_IDLE: begin
        dispatch_stall = squash_valid;
        if (squash_valid)
          state_next = (next_remaining != '0) ? REC_WALK : REC_DONE;
      end
      REC_WALK: begin
        busy           = 1'b1;
        dispatch_stall = 1'b1;
        if (next_remaining == '0) state_next = REC_DONE;
      end
      REC_DONE: begin
        busy           = 1'b1;
        dispatch_stall = 1'b1;
        if (squash_valid) begin
          state_next = (next_remaining != '0) ? REC_WALK : REC_DONE;
        end else begin
          rec_done   = 1'b1;
          state_next = REC_IDLE;
        end
      end
      default: state_next = REC_IDLE;
    endcase
  end

  always_comb begin
    rob_rd_idx = '0;
    free_valid = '0;
    free_tag   = '0;
    if (state == REC_WALK) begin
      for (int i = 0; i < N_WAY; i++) begin
        rob_rd_idx[i] = rob_wrap_sub(ptr, rem_t'(i + 1));
        free_tag[i]   = rob_rd_t[i];
        free_valid[i] = (rem_t'(i) < remaining) &&
                        (rob_rd_t[i] != phys_tag_t'(ZERO_REG_PR));
      end
    end
  end

`ifdef FLRC_PERF_EN
  logic [15:0] rec_count_q;
  logic [15:0] rec_cycles_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rec_count_q  <= '0;
      rec_cycles_q <= '0;
    end else begin
      if (load && (state_next == REC_WALK) && (rec_count_q != 16'hFFFF))
        rec_count_q <= rec_count_q + 16'd1;
      if ((state == REC_WALK) && (rec_cycles_q != 16'hFFFF))
        rec_cycles_q <= rec_cycles_q + 16'd1;
    end
  end

  assign rec_count  = rec_count_q;
  assign rec_cycles = rec_cycles_q;
`else
  assign rec_count  = '0;
  assign rec_cycles = '0;
`endif

endmodule

// File: tb/tb_freelist_recovery_ctrl.sv
// Scoreboard bench for freelist_recovery_ctrl: expected ROB indices to free are queued per squash,
// and a negedge monitor pops them as the walk is accepted.
module tb_freelist_recovery_ctrl;
  import freelist_recovery_ctrl_pkg::*;

  logic                           clock;
  logic                           reset;
  logic                           squash_valid;
  logic [IDX_W-1:0]               squash_idx;
  logic [IDX_W-1:0]               tail_idx;
  logic [N_WAY-1:0][IDX_W-1:0]    rob_rd_idx;
  logic [N_WAY-1:0][CDB_BITS-1:0] rob_rd_t;
  logic [N_WAY-1:0]               free_valid;
  logic [N_WAY-1:0][CDB_BITS-1:0] free_tag;
  logic                           free_ready;
  logic                           dispatch_stall;
  logic                           busy;
  logic                           rec_done;
  logic [15:0]                    rec_count;
  logic [15:0]                    rec_cycles;

  logic [CDB_BITS-1:0] rob_mem [N_ROB];

  // Scoreboard: ROB indices still to be released, youngest first; -1 marks the completion pulse
  int exp_q[$];
  int model_stop;
  int exp_count;
  int exp_cycles;
  int checks;
  int errors;
  bit rand_ready;

  freelist_recovery_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .squash_valid   (squash_valid),
    .squash_idx     (squash_idx),
    .tail_idx       (tail_idx),
    .rob_rd_idx     (rob_rd_idx),
    .rob_rd_t       (rob_rd_t),
    .free_valid     (free_valid),
    .free_tag       (free_tag),
    .free_ready     (free_ready),
    .dispatch_stall (dispatch_stall),
    .busy           (busy),
    .rec_done       (rec_done),
    .rec_count      (rec_count),
    .rec_cycles     (rec_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N_WAY; i++) rob_rd_t[i] = rob_mem[rob_rd_idx[i]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " free_valid"}, 32'(free_valid), 32'd0);
    checkOutput({tag, " free_tag"}, 32'(free_tag), 32'd0);
    checkOutput({tag, " rob_rd_idx"}, 32'(rob_rd_idx), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " dispatch_stall"}, 32'(dispatch_stall), 32'd0);
    checkOutput({tag, " rec_done"}, 32'(rec_done), 32'd0);
    checkOutput({tag, " rec_count"}, 32'(rec_count), 32'd0);
    checkOutput({tag, " rec_cycles"}, 32'(rec_cycles), 32'd0);
  endtask

  function automatic bit modelWalking();
    return (exp_q.size() > 0) && (exp_q[0] >= 0);
  endfunction

  // Drive one squash pulse at posedge+1, then update the scoreboard once the edge has consumed it
  task automatic applyStimulus(input int sidx, input int tidx);
    bit in_walk;
    int j;
    in_walk      = modelWalking();
    squash_valid = 1'b1;
    squash_idx   = IDX_W'(sidx);
    tail_idx     = IDX_W'(tidx);
    @(posedge clock);
    if (in_walk) begin
      j = model_stop;
      while (j != sidx) begin
        exp_q.insert(exp_q.size() - 1, j);
        j = (j + N_ROB - 1) % N_ROB;
      end
    end else begin
      exp_q.delete();
      j = (tidx + N_ROB - 1) % N_ROB;
      while (j != sidx) begin
        exp_q.push_back(j);
        j = (j + N_ROB - 1) % N_ROB;
      end
`ifdef FLRC_PERF_EN
      if (exp_q.size() > 0 && exp_count < 65535) exp_count++;
`endif
      exp_q.push_back(-1);
    end
    model_stop = sidx;
    #1;
    squash_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic monitorCycle();
    int n;
    bit walk;
    bit done_st;
    logic [N_WAY-1:0] exp_valid;
    walk    = modelWalking();
    done_st = (exp_q.size() > 0) && (exp_q[0] < 0);
    checkOutput("busy", 32'(busy), 32'(exp_q.size() > 0));
    checkOutput("dispatch_stall", 32'(dispatch_stall), 32'((exp_q.size() > 0) || squash_valid));
    checkOutput("rec_count", 32'(rec_count), 32'(exp_count));
    checkOutput("rec_cycles", 32'(rec_cycles), 32'(exp_cycles));
    n = 0;
    exp_valid = '0;
    if (walk) begin
      while (n < N_WAY && n < exp_q.size()) begin
        if (exp_q[n] < 0) break;
        n++;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (rob_mem[exp_q[i]] != CDB_BITS'(ZERO_REG_PR)) exp_valid[i] = 1'b1;
      checkOutput($sformatf("rob_rd_idx[%0d]", i), 32'(rob_rd_idx[i]), 32'(exp_q[i]));
      if (exp_valid[i])
        checkOutput($sformatf("free_tag[%0d]", i), 32'(free_tag[i]), 32'(rob_mem[exp_q[i]]));
    end
    checkOutput("free_valid", 32'(free_valid), 32'(exp_valid));
    if (walk) begin
`ifdef FLRC_PERF_EN
      if (exp_cycles < 65535) exp_cycles++;
`endif
      if (free_ready) begin
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
      end
    end
    checkOutput("rec_done", 32'(rec_done), 32'(done_st && !squash_valid));
    if (done_st && !squash_valid) void'(exp_q.pop_front());
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset) monitorCycle();
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready) free_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int rem;
    int maxk;
    int budget;
    checks       = 0;
    errors       = 0;
    exp_count    = 0;
    exp_cycles   = 0;
    model_stop   = 0;
    rand_ready   = 1'b0;
    reset        = 1'b0;
    squash_valid = 1'b0;
    squash_idx   = '0;
    tail_idx     = '0;
    free_ready   = 1'b1;
    for (int j = 0; j < N_ROB; j++) rob_mem[j] = CDB_BITS'(8 + j);

    #12;
    checkReset("init");
    #10;
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] basic walk 2..7");
    applyStimulus(2, 7);
    waitIdle();

    $display("[TB] wrapping walk");
    applyStimulus(6, 2);
    waitIdle();

    $display("[TB] empty walk");
    applyStimulus(4, 5);
    waitIdle();

    $display("[TB] free list back-pressure");
    applyStimulus(2, 7);
    free_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    free_ready = 1'b1;
    waitIdle();

    $display("[TB] zero register tag on lane 0");
    rob_mem[6] = CDB_BITS'(ZERO_REG_PR);
    applyStimulus(2, 7);
    waitIdle();
    rob_mem[6] = CDB_BITS'(14);

    $display("[TB] reset during walk");
    applyStimulus(2, 7);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_count  = 0;
    exp_cycles = 0;
    model_stop = 0;
    #1;
    checkReset("midwalk");
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end

    $display("[TB] randomized squashes");
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < N_ROB; j++) begin
        if ($urandom_range(0, 3) == 0) rob_mem[j] = CDB_BITS'(ZERO_REG_PR);
        else rob_mem[j] = CDB_BITS'($urandom_range(1, (1 << CDB_BITS) - 1));
      end
      rand_ready = 1'b1;
      applyStimulus($urandom_range(0, N_ROB - 1), $urandom_range(0, N_ROB - 1));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock);
          #1;
        end
        if (modelWalking()) begin
          rem  = exp_q.size() - 1;
          maxk = N_ROB - 1 - rem;
          if (maxk > 3) maxk = 3;
          applyStimulus((model_stop + N_ROB - $urandom_range(0, maxk)) % N_ROB,
                        $urandom_range(0, N_ROB - 1));
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        budget = 100;
        while (budget > 0 && exp_q.size() != 0) begin
          if (exp_q.size() == 1 && exp_q[0] < 0) begin
            applyStimulus($urandom_range(0, N_ROB - 1), $urandom_range(0, N_ROB - 1));
            break;
          end
          @(posedge clock);
          #1;
          budget--;
        end
      end
      waitIdle();
      rand_ready = 1'b0;
      free_ready = 1'b1;
    end

    repeat (3) begin
      @(posedge clock);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
